// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the pipeline control logic and the PC sequencer.
// The master side owns the PC; the slave side supplies the redirect and hold requests.
interface pc_sequencer_if;
    logic        stall;
    logic        imem_ready;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        exception;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic [31:0] epc;
    logic [1:0]  cause;

    modport master (
        input  stall, imem_ready, branch_taken, branch_target,
               jump, jump_target, exception, eret,
        output pc, pc_plus4, fetch_valid, flush, epc, cause
    );

    modport slave (
        output stall, imem_ready, branch_taken, branch_target,
               jump, jump_target, exception, eret,
        input  pc, pc_plus4, fetch_valid, flush, epc, cause
    );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch PC owner: picks trap/eret/jump/branch/hold/sequential next PC, traps on fetch timeout.
// Latency: redirects appear on pc (with a flush pulse) one cycle after they are accepted.
// Backpressure: stall or imem_ready low holds pc; stall defers jump/branch but never exception/eret.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0180,
    parameter int          MEM_TIMEOUT  = 16
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.master sq
);
    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic [31:0] epc_q, epc_nxt;
    logic [1:0]  cause_q, cause_nxt;
    logic        flush_q, flush_nxt;
    logic [7:0]  cnt_q, cnt_nxt;
    logic        expire;

    assign sq.pc          = pc_q;
    assign sq.pc_plus4    = pc_q + 32'd4;
    assign sq.epc         = epc_q;
    assign sq.cause       = cause_q;
    assign sq.flush       = flush_q;
    assign sq.fetch_valid = (state == RUN) && sq.imem_ready && !sq.stall;

    assign expire = (cnt_q == CNT_LAST) && !sq.imem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
            flush_q <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            epc_q   <= epc_nxt;
            cause_q <= cause_nxt;
            flush_q <= flush_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        epc_nxt   = epc_q;
        cause_nxt = cause_q;
        flush_nxt = 1'b0;
        cnt_nxt   = 8'd0;
        case (state)
            BOOT: state_nxt = RUN;
            // TRAP ignores every request, including a second exception or eret.
            TRAP: begin
                state_nxt = RUN;
                pc_nxt    = EXC_VECTOR;
            end
            RUN: begin
                if (sq.exception || expire) begin
                    epc_nxt   = pc_q;
                    cause_nxt = sq.exception ? 2'b01 : 2'b10;
                    pc_nxt    = EXC_VECTOR;
                    state_nxt = TRAP;
                    flush_nxt = 1'b1;
                end else if (sq.eret) begin
                    pc_nxt    = epc_q;
                    cause_nxt = 2'b00;
                    flush_nxt = 1'b1;
                end else if (sq.jump && !sq.stall) begin
                    pc_nxt    = {sq.jump_target[31:2], 2'b00};
                    flush_nxt = 1'b1;
                end else if (sq.branch_taken && !sq.stall) begin
                    pc_nxt    = {sq.branch_target[31:2], 2'b00};
                    flush_nxt = 1'b1;
                end else if (sq.stall || !sq.imem_ready) begin
                    // Only a missing instruction counts toward the timeout, not a hazard hold.
                    cnt_nxt = sq.imem_ready ? 8'd0 : cnt_q + 8'd1;
                end else begin
                    pc_nxt = pc_q + 32'd4;
                end
            end
            default: state_nxt = BOOT;
        endcase
    end
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expected PC, flush, epc and cause values.
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    pc_sequencer_if sq ();

    pc_sequencer #(
        .RESET_VECTOR(32'h0000_0000),
        .EXC_VECTOR  (32'h0000_0180),
        .MEM_TIMEOUT (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sq (sq.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] p, input logic f, input logic v);
        chk({tag, ".pc"}, sq.pc, p);
        chk({tag, ".flush"}, 32'(sq.flush), 32'(f));
        chk({tag, ".fv"}, 32'(sq.fetch_valid), 32'(v));
    endtask

    task automatic redirect_to(input logic [31:0] t);
        sq.jump = 1'b1;
        sq.jump_target = t;
        tick();
        sq.jump = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sq.stall = 1'b0;
        sq.imem_ready = 1'b1;
        sq.branch_taken = 1'b0;
        sq.branch_target = 32'd0;
        sq.jump = 1'b0;
        sq.jump_target = 32'd0;
        sq.exception = 1'b0;
        sq.eret = 1'b0;
        tick(2);
        chk_pc("rst", 32'h0, 1'b0, 1'b0);
        chk("rst.epc", sq.epc, 32'h0);
        chk("rst.cause", 32'(sq.cause), 32'h0);

        // BOOT then sequential fetch
        rst = 1'b0;
        #1;
        chk("boot.fv", 32'(sq.fetch_valid), 32'h0);
        tick(); chk_pc("run0", 32'h0, 1'b0, 1'b1);
        tick(); chk_pc("run4", 32'h4, 1'b0, 1'b1);
        tick(); chk_pc("run8", 32'h8, 1'b0, 1'b1);
        tick(); chk_pc("runc", 32'hC, 1'b0, 1'b1);
        tick(); chk("run10.pc", sq.pc, 32'h10);

        // Branch with misaligned target
        sq.branch_taken = 1'b1;
        sq.branch_target = 32'h43;
        tick(); chk_pc("br", 32'h40, 1'b1, 1'b1);
        sq.branch_taken = 1'b0;
        tick(); chk_pc("br+1", 32'h44, 1'b0, 1'b1);

        // Branch under stall is ignored
        redirect_to(32'h10);
        chk_pc("jmp10", 32'h10, 1'b1, 1'b1);
        sq.stall = 1'b1;
        sq.branch_taken = 1'b1;
        tick(); chk_pc("stbr1", 32'h10, 1'b0, 1'b0);
        tick(); chk_pc("stbr2", 32'h10, 1'b0, 1'b0);
        sq.stall = 1'b0;
        sq.branch_taken = 1'b0;
        tick(); chk_pc("stbr3", 32'h14, 1'b0, 1'b1);

        // Exception beats jump and stall; TRAP ignores eret
        redirect_to(32'h20);
        sq.exception = 1'b1;
        sq.jump = 1'b1;
        sq.jump_target = 32'h99;
        sq.stall = 1'b1;
        tick(); chk_pc("exc", 32'h180, 1'b1, 1'b0);
        chk("exc.epc", sq.epc, 32'h20);
        chk("exc.cause", 32'(sq.cause), 32'h1);
        sq.exception = 1'b0;
        sq.jump = 1'b0;
        sq.stall = 1'b0;
        sq.eret = 1'b1;
        tick(); chk_pc("trap", 32'h180, 1'b0, 1'b1);
        chk("trap.cause", 32'(sq.cause), 32'h1);
        sq.eret = 1'b0;
        tick(); chk_pc("vec4", 32'h184, 1'b0, 1'b1);
        tick();
        sq.eret = 1'b1;
        tick(); chk_pc("eret", 32'h20, 1'b1, 1'b1);
        chk("eret.cause", 32'(sq.cause), 32'h0);
        sq.eret = 1'b0;
        tick(); chk_pc("eret+1", 32'h24, 1'b0, 1'b1);

        // Fetch timeout: 15 held cycles, expiry on the 16th
        redirect_to(32'h8);
        sq.imem_ready = 1'b0;
        tick(15); chk_pc("to.hold", 32'h8, 1'b0, 1'b0);
        tick(); chk_pc("to.trap", 32'h180, 1'b1, 1'b0);
        chk("to.epc", sq.epc, 32'h8);
        chk("to.cause", 32'(sq.cause), 32'h2);
        sq.imem_ready = 1'b1;
        tick(); chk_pc("to.run", 32'h180, 1'b0, 1'b1);

        // Ready returns on the expiry-candidate cycle: no trap, counter cleared
        redirect_to(32'h8);
        sq.imem_ready = 1'b0;
        tick(15);
        sq.imem_ready = 1'b1;
        tick(); chk_pc("nto", 32'hC, 1'b0, 1'b1);
        sq.imem_ready = 1'b0;
        tick(15); chk_pc("nto.clr", 32'hC, 1'b0, 1'b0);
        sq.imem_ready = 1'b1;
        tick(); chk("nto.adv", sq.pc, 32'h10);

        // Reset during TRAP
        sq.exception = 1'b1;
        tick(); chk("rtrap.pre", sq.pc, 32'h180);
        sq.exception = 1'b0;
        rst = 1'b1;
        tick(); chk_pc("rtrap", 32'h0, 1'b0, 1'b0);
        chk("rtrap.epc", sq.epc, 32'h0);
        chk("rtrap.cause", 32'(sq.cause), 32'h0);
        rst = 1'b0;
        tick(); chk_pc("rtrap.run", 32'h0, 1'b0, 1'b1);

        // Reset during a timeout wait clears the counter
        redirect_to(32'h40);
        sq.imem_ready = 1'b0;
        tick(10);
        rst = 1'b1;
        tick(); chk("rwait.pc", sq.pc, 32'h0);
        rst = 1'b0;
        tick(16); chk_pc("rwait.hold", 32'h0, 1'b0, 1'b0);
        chk("rwait.cause", 32'(sq.cause), 32'h0);
        tick(); chk("rwait.trap", sq.pc, 32'h180);
        chk("rwait.tcause", 32'(sq.cause), 32'h2);
        sq.imem_ready = 1'b1;
        tick();

        // Wrap at top of address space
        redirect_to(32'hFFFF_FFFF);
        chk("wrap.pc", sq.pc, 32'hFFFF_FFFC);
        chk("wrap.plus4", sq.pc_plus4, 32'h0);
        tick(); chk_pc("wrap.adv", 32'h0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
